// File: rtl/draw_goose_phys.sv
// Sprite physics for the runner: jump/slide state machine, frame-stepped height
// and velocity, and a registered pixel hit test against the trimmed hitbox.
module draw_goose_phys #(
  parameter int COORD_W   = 10,
  parameter int POS_X     = 100,
  parameter int GROUND_Y  = 380,
  parameter int WIDTH     = 60,
  parameter int HEIGHT    = 80,
  parameter int JUMP_V0   = 15,
  parameter int GRAVITY   = 1,
  parameter int JUMP_CUT  = 40,
  parameter int SLIDE_CUT = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               freeze,
  input  logic               btnL,
  input  logic               btnR,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic               goose,
  output logic [COORD_W-1:0] pos_y,
  output logic [1:0]         state,
  output logic               jump_done
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_JUMP  = 2'd1,
    ST_SLIDE = 2'd2
  } state_e;

  // Two guard bits so ground-minus-height and the hitbox bounds never wrap.
  localparam int SW = COORD_W + 2;

  localparam logic signed [SW-1:0]      X_LO    = SW'(POS_X);
  localparam logic signed [SW-1:0]      X_HI    = SW'(POS_X + WIDTH);
  localparam logic signed [SW-1:0]      GND_S   = SW'(GROUND_Y);
  localparam logic signed [SW-1:0]      HGT_S   = SW'(HEIGHT);
  localparam logic signed [SW-1:0]      JCUT_S  = SW'(JUMP_CUT);
  localparam logic signed [SW-1:0]      SCUT_S  = SW'(SLIDE_CUT);
  localparam logic signed [COORD_W:0]   VEL0    = (COORD_W + 1)'(JUMP_V0);
  localparam logic signed [COORD_W:0]   GRAV    = (COORD_W + 1)'(GRAVITY);
  localparam int                        APEX_H  = JUMP_V0 * (JUMP_V0 + 1) / (2 * GRAVITY);

  if (APEX_H + HEIGHT > GROUND_Y) begin : g_param_check
    $error("draw_goose_phys: jump apex plus sprite height exceeds GROUND_Y");
  end

  state_e                    state_q, state_d;
  logic [COORD_W-1:0]        h_q, h_d;
  logic signed [COORD_W:0]   vel_q, vel_d;
  logic                      btnl_prev_q, btnl_prev_d;
  logic                      btnl_arm_q, btnl_arm_d;
  logic                      jump_done_q, jump_done_d;
  logic                      goose_q, goose_d;

  logic                      jump_req;
  logic signed [SW-1:0]      h_s, vel_s, h_sum, pos_y_s, cut_s, top_s, x_s, y_s;

  always_comb begin
    h_s     = $signed({2'b00, h_q});
    vel_s   = $signed({vel_q[COORD_W], vel_q});
    h_sum   = h_s + vel_s;
    pos_y_s = GND_S - h_s;
    x_s     = $signed({2'b00, x});
    y_s     = $signed({2'b00, y});
  end

  // The arm bit keeps a button held across reset from counting as a press.
  assign jump_req = btnL & ~btnl_prev_q & btnl_arm_q;

  // NOTE: every signal gets a default at the top of the block so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    vel_d       = vel_q;
    btnl_prev_d = btnl_prev_q;
    btnl_arm_d  = btnl_arm_q;
    jump_done_d = 1'b0;

    if (!freeze) begin
      btnl_prev_d = btnL;
      btnl_arm_d  = btnl_arm_q | ~btnL;
      unique case (state_q)
        ST_RUN, ST_SLIDE: begin
          if (jump_req) begin
            state_d = ST_JUMP;
            h_d     = '0;
            vel_d   = VEL0;
          end else if (btnR) begin
            state_d = ST_SLIDE;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_JUMP: begin
          if (frame_tick) begin
            if (vel_s < 0 && h_sum <= 0) begin
              h_d         = '0;
              vel_d       = '0;
              state_d     = btnR ? ST_SLIDE : ST_RUN;
              jump_done_d = 1'b1;
            end else begin
              h_d   = h_sum[COORD_W-1:0];
              vel_d = vel_q - GRAV;
            end
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    unique case (state_q)
      ST_JUMP:  cut_s = JCUT_S;
      ST_SLIDE: cut_s = SCUT_S;
      default:  cut_s = '0;
    endcase
    top_s   = pos_y_s - HGT_S + cut_s;
    goose_d = (x_s >= X_LO) && (x_s <= X_HI) && (y_s >= top_s) && (y_s <= pos_y_s);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      h_q         <= '0;
      vel_q       <= '0;
      btnl_prev_q <= 1'b0;
      btnl_arm_q  <= 1'b0;
      jump_done_q <= 1'b0;
      goose_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      vel_q       <= vel_d;
      btnl_prev_q <= btnl_prev_d;
      btnl_arm_q  <= btnl_arm_d;
      jump_done_q <= jump_done_d;
      goose_q     <= goose_d;
    end
  end

  assign pos_y     = pos_y_s[COORD_W-1:0];
  assign state     = state_q;
  assign goose     = goose_q;
  assign jump_done = jump_done_q;

endmodule

// File: tb/tb_draw_goose_phys.sv
// Directed bench for draw_goose_phys: trajectory and hitbox tables plus
// sequences for freeze, retrigger, slide priority and reset during a jump.
module tb_draw_goose_phys;

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] JUMP  = 2'd1;
  localparam logic [1:0] SLIDE = 2'd2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       frame_tick = 1'b0;
  logic       freeze = 1'b0;
  logic       btnL = 1'b0;
  logic       btnR = 1'b0;
  logic [9:0] x = '0;
  logic [9:0] y = '0;
  logic       goose;
  logic [9:0] pos_y;
  logic [1:0] state;
  logic       jump_done;

  draw_goose_phys dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .freeze     (freeze),
    .btnL       (btnL),
    .btnR       (btnR),
    .x          (x),
    .y          (y),
    .goose      (goose),
    .pos_y      (pos_y),
    .state      (state),
    .jump_done  (jump_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int jd_count = 0;

  always @(posedge clk) if (jump_done === 1'b1) jd_count <= jd_count + 1;

  typedef struct {
    logic [9:0] pos_y;
    logic [1:0] st;
    logic       jd;
  } traj_t;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       exp;
  } pix_t;

  traj_t traj[31];
  pix_t  air_pix[5];
  pix_t  slide_pix[6];
  pix_t  run_pix[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  task automatic probe(input string name, input pix_t p);
    x = p.x;
    y = p.y;
    step();
    check(name, {31'd0, goose}, {31'd0, p.exp});
  endtask

  initial begin
    int exp_y[31] = '{365, 351, 338, 326, 315, 305, 296, 288, 281, 275, 270,
                      266, 263, 261, 260, 260, 261, 263, 266, 270, 275, 281,
                      288, 296, 305, 315, 326, 338, 351, 365, 380};
    int base;
    int n;
    logic landed;

    for (int i = 0; i < 31; i++) begin
      traj[i].pos_y = 10'(exp_y[i]);
      traj[i].st    = (i == 30) ? RUN : JUMP;
      traj[i].jd    = (i == 30);
    end
    // Airborne at h=120: box x 100..160, y 220..260.
    air_pix[0] = '{10'd160, 10'd220, 1'b1};
    air_pix[1] = '{10'd161, 10'd220, 1'b0};
    air_pix[2] = '{10'd100, 10'd219, 1'b0};
    air_pix[3] = '{10'd130, 10'd260, 1'b1};
    air_pix[4] = '{10'd130, 10'd261, 1'b0};
    // Sliding on the ground: box x 100..160, y 320..380.
    slide_pix[0] = '{10'd100, 10'd320, 1'b1};
    slide_pix[1] = '{10'd100, 10'd319, 1'b0};
    slide_pix[2] = '{10'd160, 10'd380, 1'b1};
    slide_pix[3] = '{10'd161, 10'd380, 1'b0};
    slide_pix[4] = '{10'd99,  10'd350, 1'b0};
    slide_pix[5] = '{10'd100, 10'd300, 1'b0};
    // Running on the ground: box x 100..160, y 300..380.
    run_pix[0] = '{10'd100, 10'd300, 1'b1};
    run_pix[1] = '{10'd100, 10'd299, 1'b0};
    run_pix[2] = '{10'd160, 10'd381, 1'b0};
    run_pix[3] = '{10'd130, 10'd380, 1'b1};

    // Reset with btnL already held high.
    btnL = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_pos_y", 32'(pos_y), 32'd380);
    check("reset_state", 32'(state), 32'(RUN));
    check("reset_goose", {31'd0, goose}, 32'd0);
    check("reset_jump_done", {31'd0, jump_done}, 32'd0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("held_btnl_after_reset", 32'(state), 32'(RUN));

    // Single-clock press, then the full trajectory.
    btnL = 1'b0;
    step();
    btnL = 1'b1;
    step();
    btnL = 1'b0;
    check("jump_start_state", 32'(state), 32'(JUMP));
    check("jump_start_pos_y", 32'(pos_y), 32'd380);
    base = jd_count;
    for (int i = 0; i < 31; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      check($sformatf("traj_pos_y_t%0d", i + 1), 32'(pos_y), 32'(traj[i].pos_y));
      check($sformatf("traj_state_t%0d", i + 1), 32'(state), 32'(traj[i].st));
      check($sformatf("traj_jd_t%0d", i + 1), {31'd0, jump_done}, {31'd0, traj[i].jd});
      step();
      if (i == 14) begin
        for (int k = 0; k < 5; k++) probe($sformatf("air_goose_%0d", k), air_pix[k]);
      end
    end
    check("jump_done_cleared", {31'd0, jump_done}, 32'd0);
    check("jump_done_pulse_count", 32'(jd_count - base), 32'd1);

    // Slide held for ten clocks, then released.
    btnR = 1'b1;
    step();
    check("slide_state", 32'(state), 32'(SLIDE));
    for (int k = 0; k < 6; k++) probe($sformatf("slide_goose_%0d", k), slide_pix[k]);
    repeat (3) step();
    check("slide_state_held", 32'(state), 32'(SLIDE));
    btnR = 1'b0;
    step();
    check("slide_release_state", 32'(state), 32'(RUN));
    for (int k = 0; k < 4; k++) probe($sformatf("run_goose_%0d", k), run_pix[k]);

    // Jump with btnL held throughout; freeze after tick 10 for 20 ticks.
    btnL = 1'b1;
    step();
    check("jump2_state", 32'(state), 32'(JUMP));
    repeat (10) frame();
    check("pre_freeze_pos_y", 32'(pos_y), 32'd275);
    freeze = 1'b1;
    for (int i = 0; i < 20; i++) begin
      frame();
      check($sformatf("frozen_pos_y_%0d", i), 32'(pos_y), 32'd275);
    end
    check("frozen_state", 32'(state), 32'(JUMP));
    freeze = 1'b0;
    n = 0;
    landed = 1'b0;
    while (!landed && n < 40) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      n++;
      if (jump_done) landed = 1'b1;
      step();
    end
    check("freeze_landed", {31'd0, landed}, 32'd1);
    check("freeze_ticks_to_land", 32'(n), 32'd21);
    repeat (3) step();
    check("held_btnl_no_retrigger", 32'(state), 32'(RUN));
    check("landed_pos_y", 32'(pos_y), 32'd380);

    // A press while sliding takes priority; btnR is then ignored in the air.
    btnL = 1'b0;
    btnR = 1'b1;
    step();
    check("prio_slide_state", 32'(state), 32'(SLIDE));
    btnL = 1'b1;
    step();
    check("prio_jump_state", 32'(state), 32'(JUMP));
    step();
    check("btnr_ignored_in_jump", 32'(state), 32'(JUMP));
    btnR = 1'b0;

    // Reset during the jump after tick 8.
    base = jd_count;
    repeat (8) frame();
    check("pre_reset_pos_y", 32'(pos_y), 32'd288);
    rst_n = 1'b0;
    #1;
    check("midjump_reset_pos_y", 32'(pos_y), 32'd380);
    check("midjump_reset_state", 32'(state), 32'(RUN));
    check("midjump_reset_jd", {31'd0, jump_done}, 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    check("post_reset_no_jump", 32'(state), 32'(RUN));
    check("midjump_no_jd_pulse", 32'(jd_count - base), 32'd0);
    btnL = 1'b0;
    step();
    btnL = 1'b1;
    step();
    check("post_reset_repress_jump", 32'(state), 32'(JUMP));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
